// File: rtl/src_stream_loader.sv
// AXI-Stream to ping-pong source buffer loader: splits 32-bit beats into two 16-bit
// writes, closes a bank on tlast or when it fills, and hands it off via bank_full.
module src_stream_loader #(
  parameter int BANK_AW = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [31:0]        s_axis_tdata,
  input  logic [3:0]         s_axis_tkeep,
  input  logic               s_axis_tlast,
  output logic               src_v,
  output logic [BANK_AW:0]   src_a,
  output logic [15:0]        src_d,
  output logic [1:0]         bank_full,
  output logic [BANK_AW:0]   bank_len0,
  output logic [BANK_AW:0]   bank_len1,
  input  logic [1:0]         bank_free
);

  // state | meaning
  // IDLE  | wait until the fill bank is released by compute
  // LOAD  | tready=1, accept one beat
  // WR_LO | low sample on the write port
  // WR_HI | high sample on the write port
  // CLOSE | mark fill bank full, record length, switch banks
  typedef enum logic [2:0] {IDLE, LOAD, WR_LO, WR_HI, CLOSE} state_t;

  localparam logic [BANK_AW:0]   LAST_IDX = {1'b0, {BANK_AW{1'b1}}};
  localparam logic [BANK_AW:0]   CNT_ONE  = {{BANK_AW{1'b0}}, 1'b1};
  localparam logic [BANK_AW-1:0] IDX_ONE  = {{(BANK_AW-1){1'b0}}, 1'b1};

  state_t             state, state_nxt;
  logic               fill_bank;
  logic [BANK_AW:0]   cnt;
  logic [15:0]        hi_q;
  logic               lo_only_q;
  logic               last_q;
  logic [BANK_AW:0]   len_q [2];
  logic               at_end;
  logic [BANK_AW-1:0] idx_nxt;

  assign at_end        = (cnt == LAST_IDX);
  assign idx_nxt       = cnt[BANK_AW-1:0] + IDX_ONE;
  assign s_axis_tready = (state == LOAD);
  assign bank_len0     = len_q[0];
  assign bank_len1     = len_q[1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bank_full[fill_bank]) state_nxt = LOAD;
      LOAD:    if (s_axis_tvalid) state_nxt = WR_LO;
      // a beat straddling the bank end loses its high half
      WR_LO:   state_nxt = (lo_only_q || at_end) ? CLOSE : WR_HI;
      WR_HI:   state_nxt = (last_q || at_end) ? CLOSE : LOAD;
      CLOSE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fill_bank <= 1'b0;
      cnt       <= '0;
      hi_q      <= '0;
      lo_only_q <= 1'b0;
      last_q    <= 1'b0;
      src_v     <= 1'b0;
      src_a     <= '0;
      src_d     <= '0;
      bank_full <= '0;
      for (int b = 0; b < 2; b++) len_q[b] <= '0;
    end else begin
      state <= state_nxt;
      src_v <= 1'b0;

      for (int b = 0; b < 2; b++) begin
        if (bank_free[b] && bank_full[b]) begin
          bank_full[b] <= 1'b0;
          len_q[b]     <= '0;
        end
      end

      case (state)
        LOAD: begin
          if (s_axis_tvalid) begin
            hi_q      <= s_axis_tdata[31:16];
            lo_only_q <= (s_axis_tkeep == 4'h3) && s_axis_tlast;
            last_q    <= s_axis_tlast;
            src_v     <= 1'b1;
            src_a     <= {fill_bank, cnt[BANK_AW-1:0]};
            src_d     <= s_axis_tdata[15:0];
          end
        end
        WR_LO: begin
          cnt <= cnt + CNT_ONE;
          if (state_nxt == WR_HI) begin
            src_v <= 1'b1;
            src_a <= {fill_bank, idx_nxt};
            src_d <= hi_q;
          end
        end
        WR_HI: cnt <= cnt + CNT_ONE;
        CLOSE: begin
          // the closing bank is never full, so a same-cycle free on it is moot
          bank_full[fill_bank] <= 1'b1;
          len_q[fill_bank]     <= cnt;
          cnt                  <= '0;
          fill_bank            <= ~fill_bank;
        end
        default: ;
      endcase
    end
  end

endmodule
